// File: rtl/tt_um_restador_serial_pkg.sv
// Shared definitions for the bit-serial subtractor tile: state encoding,
// default operand width and the uo_out bit map.
package restador_pkg;

  localparam int WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int BIT_BORROW = 4;
  localparam int BIT_BUSY   = 5;
  localparam int BIT_DONE   = 6;
  localparam int BIT_ZERO   = 7;

endpackage

// File: rtl/tt_um_restador_serial_if.sv
// Tiny Tapeout tile pin bundle: the harness side drives enable, operands and
// control; the tile side returns the result/status and the bidir controls.
interface tt_um_restador_serial_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/tt_um_restador_serial_full_sub.sv
// One-bit full subtractor, the dual of the ripple full-adder cell:
// d = a - b - bin (mod 2), bout set when that difference went negative.
module full_sub_1bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/tt_um_restador_serial.sv
// Bit-serial subtractor tile: D = A - B computed LSB first through a single
// full-subtractor cell and a borrow flop, with a start/busy/done handshake.
module tt_um_restador_serial
  import restador_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   diff_sh;
  logic [WIDTH-1:0]   res_q;
  logic [CNT_W-1:0]   cnt;
  logic               borrow;
  logic               borrow_q;
  logic               start_q;
  logic               done;
  logic               zero_q;

  logic               start_edge;
  logic               cell_d;
  logic               cell_bout;
  logic [WIDTH-1:0]   diff_next;
  logic               busy;
  logic               unused_ok;

  assign start_edge = uio_in[0] & ~start_q;
  assign diff_next  = {cell_d, diff_sh[WIDTH-1:1]};
  assign busy       = (state == ST_SHIFT);

  full_sub_1bit u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (borrow),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // Control FSM and serial datapath; everything freezes while ena is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      diff_sh  <= '0;
      res_q    <= '0;
      cnt      <= '0;
      borrow   <= 1'b0;
      borrow_q <= 1'b0;
      start_q  <= 1'b0;
      done     <= 1'b0;
      zero_q   <= 1'b0;
    end else if (ena) begin
      start_q <= uio_in[0];
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_edge) begin
            a_sh    <= ui_in[WIDTH-1:0];
            b_sh    <= ui_in[WIDTH+3:4];
            diff_sh <= '0;
            borrow  <= 1'b0;
            cnt     <= '0;
            done    <= 1'b0;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // A start edge here is consumed by start_q but otherwise ignored.
          diff_sh <= diff_next;
          a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
          borrow  <= cell_bout;
          cnt     <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            res_q    <= diff_next;
            borrow_q <= cell_bout;
            zero_q   <= (diff_next == '0);
            done     <= 1'b1;
            state    <= ST_DONE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign uo_out    = {zero_q, done, busy, borrow_q, res_q};
  assign uio_out   = 8'h00;
  assign uio_oe    = 8'h00;
  assign unused_ok = &{1'b0, uio_in[7:1]};

endmodule

// File: tb/tb_tt_um_restador_serial.sv
// Self-checking bench for the bit-serial subtractor tile. Expected uo_out
// words are computed from the operands and queued when an operation starts,
// then popped and compared when done rises.
module tb_tt_um_restador_serial;
  import restador_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [7:0] exp_q[$];
  logic [7:0] last_exp;

  tt_um_restador_serial_if bus ();

  tt_um_restador_serial dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (bus.ena),
    .ui_in   (bus.ui_in),
    .uio_in  (bus.uio_in),
    .uo_out  (bus.uo_out),
    .uio_out (bus.uio_out),
    .uio_oe  (bus.uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] model(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] d;
    d = a - b;
    return {(d == 4'd0), 1'b1, 1'b0, (a < b), d};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive operands and raise start for exactly the capture edge E0.
  task automatic start_op(input logic [3:0] a, input logic [3:0] b);
    bus.ui_in     = {b, a};
    bus.uio_in[0] = 1'b1;
    cyc();
    bus.uio_in[0] = 1'b0;
  endtask

  // Cycles until done; -1 if it never comes within the budget.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!bus.uo_out[BIT_DONE] && cycles < 20) begin
      cyc();
      cycles++;
    end
    if (!bus.uo_out[BIT_DONE]) cycles = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    n_checks++;
    if (bus.uo_out !== 8'h00) begin
      n_fail++; $display("FAIL reset_uo_out got=%h exp=00", bus.uo_out);
    end
    n_checks++;
    if ({bus.uio_out, bus.uio_oe} !== 16'h0000) begin
      n_fail++; $display("FAIL reset_uio got=%h exp=0000", {bus.uio_out, bus.uio_oe});
    end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    logic [7:0] exp;
    exp_q.push_back(model(4'd9, 4'd3));
    start_op(4'd9, 4'd3);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({bus.uo_out[BIT_DONE], bus.uo_out[BIT_BUSY]} !== 2'b01) begin
        n_fail++; $display("FAIL basic_busy[%0d] got done,busy=%b exp=01", i,
                           {bus.uo_out[BIT_DONE], bus.uo_out[BIT_BUSY]});
      end
      cyc();
    end
    exp = exp_q.pop_front();
    n_checks++;
    if (bus.uo_out !== exp || bus.uo_out !== 8'h46) begin
      n_fail++; $display("FAIL basic_result got=%h exp=%h", bus.uo_out, exp);
    end
    last_exp = exp;
  endtask

  task automatic test_underflow();
    int cyc_n;
    logic [7:0] exp;
    exp_q.push_back(model(4'd3, 4'd9));
    start_op(4'd3, 4'd9);
    wait_done(cyc_n);
    n_checks++;
    if (cyc_n + 1 !== 5) begin
      n_fail++; $display("FAIL underflow_latency got=%0d edges exp=5", cyc_n + 1);
    end
    exp = exp_q.pop_front();
    n_checks++;
    if (bus.uo_out !== exp) begin
      n_fail++; $display("FAIL underflow_result got=%h exp=%h", bus.uo_out, exp);
    end
    last_exp = exp;
  endtask

  task automatic test_equal();
    int cyc_n;
    logic [7:0] exp;
    logic [3:0] a_tab[2] = '{4'd5, 4'd15};
    logic [3:0] b_tab[2] = '{4'd5, 4'd0};
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(model(a_tab[i], b_tab[i]));
      start_op(a_tab[i], b_tab[i]);
      wait_done(cyc_n);
      exp = exp_q.pop_front();
      n_checks++;
      if (cyc_n !== 4 || bus.uo_out !== exp) begin
        n_fail++; $display("FAIL equal_tab[%0d] got=%h cycles=%0d exp=%h cycles=4",
                           i, bus.uo_out, cyc_n, exp);
      end
      last_exp = exp;
    end
  endtask

  task automatic test_hold_start();
    int busy_n = 0;
    logic [7:0] exp;
    exp_q.push_back(model(4'd6, 4'd1));
    bus.ui_in     = {4'd1, 4'd6};
    bus.uio_in[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (bus.uo_out[BIT_BUSY]) busy_n++;
    end
    bus.uio_in[0] = 1'b0;
    n_checks++;
    if (busy_n !== 4) begin
      n_fail++; $display("FAIL hold_busy_cycles got=%0d exp=4", busy_n);
    end
    exp = exp_q.pop_front();
    n_checks++;
    if (bus.uo_out !== exp) begin
      n_fail++; $display("FAIL hold_result got=%h exp=%h", bus.uo_out, exp);
    end
    last_exp = exp;
    cyc();
  endtask

  task automatic test_toggle_in_shift();
    logic [7:0] exp;
    exp_q.push_back(model(4'd12, 4'd5));
    start_op(4'd12, 4'd5);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bus.uo_out[3:0] !== last_exp[3:0] || !bus.uo_out[BIT_BUSY]) begin
        n_fail++; $display("FAIL toggle_hold_d[%0d] got=%h exp_d=%h busy=1",
                           i, bus.uo_out, last_exp[3:0]);
      end
      bus.uio_in[0] = ~bus.uio_in[0];
      cyc();
    end
    bus.uio_in[0] = 1'b1;
    cyc();
    exp = exp_q.pop_front();
    n_checks++;
    if (bus.uo_out !== exp) begin
      n_fail++; $display("FAIL toggle_result got=%h exp=%h", bus.uo_out, exp);
    end
    cyc();
    cyc();
    n_checks++;
    if (bus.uo_out !== exp) begin
      n_fail++; $display("FAIL toggle_no_restart got=%h exp=%h", bus.uo_out, exp);
    end
    last_exp = exp;
    bus.uio_in[0] = 1'b0;
    cyc();
  endtask

  task automatic test_restart_in_done();
    int cyc_n;
    logic [7:0] exp;
    exp_q.push_back(model(4'd2, 4'd7));
    start_op(4'd2, 4'd7);
    n_checks++;
    if (bus.uo_out !== ((last_exp & 8'hBF) | 8'h20)) begin
      n_fail++; $display("FAIL restart_capture got=%h exp=%h", bus.uo_out,
                         (last_exp & 8'hBF) | 8'h20);
    end
    wait_done(cyc_n);
    exp = exp_q.pop_front();
    n_checks++;
    if (bus.uo_out !== exp) begin
      n_fail++; $display("FAIL restart_result got=%h exp=%h", bus.uo_out, exp);
    end
    last_exp = exp;
  endtask

  task automatic test_ena_pause();
    int cyc_n;
    logic [7:0] exp;
    logic [7:0] frozen;
    exp_q.push_back(model(4'd10, 4'd4));
    start_op(4'd10, 4'd4);
    cyc();
    cyc();
    bus.ena = 1'b0;
    frozen = (last_exp & 8'hBF) | 8'h20;
    for (int i = 0; i < 3; i++) begin
      bus.uio_in[0] = (i == 1);
      cyc();
      n_checks++;
      if (bus.uo_out !== frozen) begin
        n_fail++; $display("FAIL pause_frozen[%0d] got=%h exp=%h", i, bus.uo_out, frozen);
      end
    end
    bus.uio_in[0] = 1'b0;
    bus.ena = 1'b1;
    wait_done(cyc_n);
    n_checks++;
    if (cyc_n !== 2) begin
      n_fail++; $display("FAIL pause_resume_cycles got=%0d exp=2", cyc_n);
    end
    exp = exp_q.pop_front();
    n_checks++;
    if (bus.uo_out !== exp) begin
      n_fail++; $display("FAIL pause_result got=%h exp=%h", bus.uo_out, exp);
    end
    last_exp = exp;
  endtask

  task automatic test_reset_mid();
    int cyc_n;
    int seen_done = 0;
    logic [7:0] exp;
    start_op(4'd13, 4'd6);
    cyc();
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    n_checks++;
    if (bus.uo_out !== 8'h00) begin
      n_fail++; $display("FAIL midreset_uo_out got=%h exp=00", bus.uo_out);
    end
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (bus.uo_out !== 8'h00) seen_done++;
    end
    n_checks++;
    if (seen_done !== 0) begin
      n_fail++; $display("FAIL midreset_idle got=%0d nonzero cycles exp=0", seen_done);
    end
    exp_q.push_back(model(4'd7, 4'd2));
    start_op(4'd7, 4'd2);
    wait_done(cyc_n);
    exp = exp_q.pop_front();
    n_checks++;
    if (cyc_n !== 4 || bus.uo_out !== exp) begin
      n_fail++; $display("FAIL midreset_fresh got=%h cycles=%0d exp=%h cycles=4",
                         bus.uo_out, cyc_n, exp);
    end
    last_exp = exp;
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    last_exp      = 8'h00;
    rst_n         = 1'b0;
    bus.ena       = 1'b1;
    bus.ui_in     = 8'h00;
    bus.uio_in    = 8'h00;
    test_reset();
    test_basic();
    test_underflow();
    test_equal();
    test_hold_start();
    test_toggle_in_shift();
    test_restart_in_done();
    test_ena_pause();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++; $display("FAIL scoreboard_drain got=%0d left exp=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
